// File: rtl/counter_pkg.sv
// Shared types and constants for the board-level up/down counter:
// seven-segment codes (active-low, bit0 = a ... bit6 = g) and the board clock rate.
package counter_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Non-decimal nibbles fall back to a dark digit rather than garbage.
  function automatic seg7_t to_seg7(input logic [3:0] digit);
    seg7_t seg;
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = SEG_DIGIT[digit];
    return seg;
  endfunction

endpackage

// File: rtl/sync_clock_divider.sv
// Divides the board clock into a 50% duty square wave and a one-cycle tick
// that fires in the cycle right before each rising edge of that wave.
module sync_clock_divider #(
  parameter logic [31:0] MaxClockBuf = 32'd25
) (
  input  logic clock,
  input  logic reset,
  output logic o_sync_clock,
  output logic o_tick
);

  logic [31:0] div_count;
  logic        wrap;

  assign wrap   = (div_count == MaxClockBuf - 32'd1);
  assign o_tick = wrap & ~o_sync_clock;

  // reset is active-low; a mid-period reset drops any pending tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_count    <= '0;
      o_sync_clock <= 1'b0;
    end else if (wrap) begin
      div_count    <= '0;
      o_sync_clock <= ~o_sync_clock;
    end else begin
      div_count <= div_count + 32'd1;
    end
  end

endmodule

// File: rtl/top_entity.sv
// 5-bit up/down counter stepped by a divided tick, shown on LEDs and on five
// seven-segment digits in either decimal or per-bit binary form.
module top_entity
  import counter_pkg::*;
#(
  parameter int         Frequency = 1,
  parameter logic [4:0] Initial   = 5'b00000
) (
  input  logic            i_clock_50mhz,
  input  logic            i_reset,
  input  logic            i_set,
  input  logic            i_pause,
  input  logic            i_count,
  input  logic            i_type,
  output logic [4:0][6:0] o_HEXs,
  output logic [4:0]      o_LEDs,
  output logic            o_sync_clock
);

  localparam logic [31:0] MaxClockBuf = 32'(CLK_HZ / (Frequency * 2));

  logic       tick;
  logic [4:0] count;

  sync_clock_divider #(
    .MaxClockBuf (MaxClockBuf)
  ) u_divider (
    .clock        (i_clock_50mhz),
    .reset        (i_reset),
    .o_sync_clock (o_sync_clock),
    .o_tick       (tick)
  );

  // Count moves on the same edge that raises o_sync_clock; 5-bit wrap is natural.
  always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (tick) begin
      if (i_set)        count <= Initial;
      else if (i_pause) count <= count;
      else if (i_count) count <= count + 5'd1;
      else              count <= count - 5'd1;
    end
  end

  assign o_LEDs = count;

  always_comb begin
    logic [3:0] units;
    logic [3:0] tens;
    units  = 4'(count % 5'd10);
    tens   = 4'(count / 5'd10);
    o_HEXs = {5{SEG_BLANK}};
    if (i_type) begin
      for (int k = 0; k < 5; k++) begin
        o_HEXs[k] = count[k] ? SEG_DIGIT[1] : SEG_DIGIT[0];
      end
    end else begin
      o_HEXs[0] = to_seg7(units);
      o_HEXs[1] = to_seg7(tens);
    end
  end

endmodule

// File: tb/tb_top_entity.sv
// Self-checking bench for top_entity: a tick-accurate model pushes expected
// counts into a scoreboard that is drained on every rising o_sync_clock.
module tb_top_entity;

  logic            clock = 1'b0;
  logic            resetN;
  logic            iSet;
  logic            iPause;
  logic            iCount;
  logic            iType;
  logic [4:0][6:0] hexs;
  logic [4:0]      leds;
  logic            syncClock;

  int         assertCount = 0;
  int         failCount   = 0;
  int         edgeN       = 0;
  logic [4:0] modelCount  = '0;
  logic [4:0] expQ [$];
  logic       prevSync    = 1'b0;
  int         n;
  logic [34:0] binNine;

  logic [6:0] segTable [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  always #10 clock = ~clock;

  top_entity #(
    .Frequency (1_000_000),
    .Initial   (5'b01001)
  ) dut (
    .i_clock_50mhz (clock),
    .i_reset       (resetN),
    .i_set         (iSet),
    .i_pause       (iPause),
    .i_count       (iCount),
    .i_type        (iType),
    .o_HEXs        (hexs),
    .o_LEDs        (leds),
    .o_sync_clock  (syncClock)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic set, input logic pause, input logic up, input logic mode);
    iSet   = set;
    iPause = pause;
    iCount = up;
    iType  = mode;
  endtask

  task automatic waitCycles(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  // Returns the number of falling clock edges until a rising o_sync_clock is seen.
  task automatic waitTick(output int cycles);
    logic prev;
    logic seen;
    cycles = 0;
    seen   = 1'b0;
    prev   = syncClock;
    while (!seen && cycles < 100) begin
      @(negedge clock);
      cycles++;
      if (!prev && syncClock) seen = 1'b1;
      prev = syncClock;
    end
    checkOutput("tick_wait", seen, 1'b1);
  endtask

  function automatic logic [4:0] nextCount(input logic [4:0] c, input logic set,
                                           input logic pause, input logic up);
    if (set)        return 5'b01001;
    else if (pause) return c;
    else if (up)    return (c == 5'd31) ? 5'd0 : c + 5'd1;
    else            return (c == 5'd0) ? 5'd31 : c - 5'd1;
  endfunction

  function automatic logic [34:0] expHex(input logic [4:0] c, input logic mode);
    logic [34:0] h;
    int          v;
    h = {35{1'b1}};
    v = int'(c);
    if (mode) begin
      for (int k = 0; k < 5; k++) h[k*7 +: 7] = c[k] ? segTable[1] : segTable[0];
    end else begin
      h[6:0]  = segTable[v % 10];
      h[13:7] = segTable[v / 10];
    end
    return h;
  endfunction

  // Reference model: with MaxClockBuf = 25 the tick lands on edges 25, 75, 125 ...
  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      edgeN      = 0;
      modelCount = '0;
      expQ.delete();
    end else begin
      edgeN++;
      if (edgeN % 50 == 25) begin
        modelCount = nextCount(modelCount, iSet, iPause, iCount);
        expQ.push_back(modelCount);
      end
    end
  end

  always @(negedge clock) begin
    #2;
    checkOutput("sync_clock", syncClock, (edgeN >= 25) && ((edgeN / 25) % 2 == 1));
    checkOutput("leds", leds, modelCount);
    checkOutput("hexs", hexs, expHex(modelCount, iType));
    if (!prevSync && syncClock) begin
      checkOutput("sb_pending", expQ.size() != 0, 1'b1);
      if (expQ.size() != 0) checkOutput("sb_leds", leds, expQ.pop_front());
    end
    prevSync = syncClock;
  end

  initial begin
    binNine = {7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1111001};
    resetN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(5);
    resetN = 1'b1;

    $display("[TB] divider timing and first up-counts");
    waitTick(n);
    checkOutput("first_rise_delay", n, 25);
    checkOutput("leds_tick1", leds, 5'd1);
    waitTick(n);
    checkOutput("sync_period", n, 50);
    checkOutput("leds_tick2", leds, 5'd2);

    $display("[TB] long reset mid-period");
    waitCycles(10);
    resetN = 1'b0;
    waitCycles(2000);
    checkOutput("reset_leds", leds, 5'd0);
    checkOutput("reset_sync", syncClock, 1'b0);
    checkOutput("reset_hex0", hexs[0], 7'b1000000);
    checkOutput("reset_hex1", hexs[1], 7'b1000000);
    checkOutput("reset_hex_blank", hexs[4:2], {3{7'b1111111}});
    resetN = 1'b1;

    $display("[TB] load initial value");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitTick(n);
    checkOutput("reset_restart_delay", n, 25);
    checkOutput("set_leds", leds, 5'b01001);
    checkOutput("set_hex1", hexs[1], 7'b1000000);
    checkOutput("set_hex0", hexs[0], 7'b0010000);
    waitTick(n);
    checkOutput("set_held", leds, 5'd9);

    $display("[TB] pause then resume");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) waitTick(n);
    checkOutput("pause_leds", leds, 5'd9);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitTick(n);
    checkOutput("resume_leds", leds, 5'd10);

    $display("[TB] binary display mode");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitTick(n);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("binary_nine", hexs, binNine);
    iType = 1'b0;
    #1;
    checkOutput("decimal_nine_hex0", hexs[0], 7'b0010000);

    $display("[TB] down-count wrap and up-count wrap");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) waitTick(n);
    checkOutput("down_to_one", leds, 5'd1);
    waitTick(n);
    checkOutput("down_to_zero", leds, 5'd0);
    waitTick(n);
    checkOutput("down_wrap", leds, 5'd31);
    checkOutput("wrap_hex1", hexs[1], 7'b0110000);
    checkOutput("wrap_hex0", hexs[0], 7'b1111001);
    waitTick(n);
    checkOutput("down_thirty", leds, 5'd30);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitTick(n);
    checkOutput("up_thirtyone", leds, 5'd31);
    waitTick(n);
    checkOutput("up_wrap", leds, 5'd0);

    waitCycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
